// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder.
// State encoding and bit-counter sizing live here so the top and bench agree.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // Counter must index WIDTH bit positions; never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width <= 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_adder_fa_cell.sv
// 1-bit half-adder cell and the full-adder cell built from two of them plus an OR.
// Purely combinational; the serial adder uses one fa_cell per clock for the current bit.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s0;
    logic c0;
    logic c1;

    ha_cell u_ha0 (.a(a),  .b(b),  .s(s0), .c(c0));
    ha_cell u_ha1 (.a(s0), .b(ci), .s(s),  .c(c1));

    assign co = c0 | c1;
endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one sum bit per clock, LSB first, carry held in a register.
// Optional signed-overflow output is enabled with `define SERIAL_ADDER_OVF_EN.
//
// state    | meaning
// ---------+----------------------------------------------
// ST_IDLE  | waiting for start; sum/cout hold last result
// ST_SHIFT | one bit added per edge, WIDTH edges in total
// ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic bit_s;
    logic bit_c;

    fa_cell u_fa (
        .a  (op_a_q[0]),
        .b  (op_b_q[0]),
        .ci (carry_q),
        .s  (bit_s),
        .co (bit_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_a_d  = a;
                    op_b_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                sum_d   = {bit_s, sum_q[WIDTH-1:1]};
                carry_d = bit_c;
                op_a_d  = op_a_q >> 1;
                op_b_d  = op_b_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    cout_d  = bit_c;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this final edge
                    ovf_d   = carry_q ^ bit_c;
`endif
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_SHIFT);
    assign done = (state_q == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule
